systolic_drain: RTL

//  Result-side collector for the systolic array. Samples the array's skewed

---
 rtl/systolic_drain.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/systolic_drain.sv
`timescale 1ns/1ps
// systolic_drain
//   Collects the skewed output row of the systolic array, realigns the
//   diagonal wavefront into whole result vectors and queues them in a
//   first-word-fall-through FIFO. The array cannot be stalled, so this block
//   never pushes back on it; a vector arriving while the FIFO is full (and not
//   popped in the same cycle) is dropped and flagged on a sticky overflow bit.
//
//   Output stream handshake: a vector transfers on every rising edge where
//   out_valid && out_ready. out_valid depends only on FIFO occupancy, never on
//   out_ready, and out_data stays stable while out_valid && !out_ready.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   start             begin a capture job (honoured only in IDLE)
//   first_lat         cycles from start to column 0 of vector 0
//   num_rows          number of result vectors in the job
//   row_in            array output row, column c at [c*SUM_WIDTH +: SUM_WIDTH]
//   out_data          aligned vector at the FIFO head (0 when empty)
//   out_valid         FIFO not empty
//   out_ready         sink accepts out_data
//   busy              job in progress
//   done              one-cycle pulse at job end
//   overflow          sticky: a vector was dropped
//   dbg_state         current FSM state (IDLE=0, WAIT=1, CAPTURE=2, FLUSH=3)
module systolic_drain #(
    parameter int ARRAY_SIZE = 8,
    parameter int DATA_WIDTH = 4,
    parameter int SUM_WIDTH  = DATA_WIDTH * DATA_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int LAT_W      = 8,
    parameter int CNT_W      = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [LAT_W-1:0]                first_lat,
    input  logic [CNT_W-1:0]                num_rows,
    input  logic [ARRAY_SIZE*SUM_WIDTH-1:0] row_in,
    output logic [ARRAY_SIZE*SUM_WIDTH-1:0] out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow,
    output logic [1:0]                      dbg_state
);
    localparam int VW    = ARRAY_SIZE * SUM_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    // The FSM enters CAPTURE one edge before the first aligned vector, so the
    // wait count is first_lat + ARRAY_SIZE - 2 decrements long.
    localparam logic [LAT_W:0] WAIT_BIAS = (LAT_W+1)'(ARRAY_SIZE - 2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_FLUSH} state_t;

    state_t            state, state_n;
    logic [LAT_W:0]    wait_cnt, wait_cnt_n;
    logic [CNT_W-1:0]  row_cnt, row_cnt_n;
    logic              done_n, overflow_n;

    logic [VW-1:0]     aligned;
    logic [VW-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              push, pop, full, push_ok, drop;

    // Deskew: column c is delayed by ARRAY_SIZE-1-c registers; the last
    // column is already the newest element of the wavefront and passes as-is.
    for (genvar c = 0; c < ARRAY_SIZE - 1; c++) begin : g_col
        localparam int D = ARRAY_SIZE - 1 - c;
        logic [SUM_WIDTH-1:0] pipe [D];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < D; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= row_in[c*SUM_WIDTH +: SUM_WIDTH];
                for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign aligned[c*SUM_WIDTH +: SUM_WIDTH] = pipe[D-1];
    end
    assign aligned[(ARRAY_SIZE-1)*SUM_WIDTH +: SUM_WIDTH] =
        row_in[(ARRAY_SIZE-1)*SUM_WIDTH +: SUM_WIDTH];

    // FIFO control
    assign out_valid = (occ != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign pop       = out_valid && out_ready;
    assign full      = (occ == OCC_W'(FIFO_DEPTH));
    assign push      = (state == S_CAPTURE);
    // A full FIFO still takes the vector when the head leaves in the same cycle.
    assign push_ok   = push && (!full || pop);
    assign drop      = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= aligned;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            row_cnt  <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            row_cnt  <= row_cnt_n;
            done     <= done_n;
            overflow <= overflow_n;
        end
    end

    // FSM next state
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        row_cnt_n  = row_cnt;
        done_n     = 1'b0;
        overflow_n = overflow || drop;
        case (state)
            S_IDLE: begin
                if (start) begin
                    overflow_n = 1'b0;
                    if (num_rows == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n    = S_WAIT;
                        wait_cnt_n = {1'b0, first_lat} + WAIT_BIAS;
                        row_cnt_n  = num_rows;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) state_n = S_CAPTURE;
                else                wait_cnt_n = wait_cnt - (LAT_W+1)'(1);
            end
            S_CAPTURE: begin
                // Dropped vectors still consume a row slot.
                row_cnt_n = row_cnt - CNT_W'(1);
                if (row_cnt == CNT_W'(1)) state_n = S_FLUSH;
            end
            S_FLUSH: begin
                if (occ == '0 || (occ == OCC_W'(1) && pop)) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;
endmodule
